serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing a - b, LSB first,
// one bit pair per clock.
//   Parameter WIDTH : operand/result width in bits (2..32).
//   clk, rst        : rising-edge clock, asynchronous active-high reset.
//   start, a, b     : request plus minuend/subtrahend, captured when accepted in IDLE.
//   busy            : high while the RUN state is shifting bits.
//   done            : one-cycle pulse in DONE, when diff/bout are final.
//   diff, bout      : a - b modulo 2^WIDTH, and the final borrow (a < b unsigned).
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_bit_c;
   logic             br_nxt_c;
   logic             last_c;

   // One full-subtractor step on the current LSBs.
   assign d_bit_c  = a_q[0] ^ b_q[0] ^ br_q;
   assign br_nxt_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign last_c   = (cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded from the upcoming state so they register in step with it.
   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // Datapath next values: capture on accept, shift one bit per RUN cycle.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      br_d   = br_q;
      cnt_d  = cnt_q;
      bout_d = bout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               br_d  = 1'b0;
               cnt_d = '0;
            end
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = {d_bit_c, res_q[WIDTH-1:1]};
            br_d  = br_nxt_c;
            if (last_c) begin
               bout_d = br_nxt_c;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         br_q   <= 1'b0;
         cnt_q  <= '0;
         bout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         br_q   <= br_d;
         cnt_q  <= cnt_d;
         bout_q <= bout_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = res_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int n_vec = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer subtraction; borrow is the sign of the true difference.
   function automatic logic [8:0] ref_sub(input logic [7:0] ra, input logic [7:0] rb);
      int d;
      d = int'(ra) - int'(rb);
      return {(d < 0) ? 1'b1 : 1'b0, 8'(d)};
   endfunction

   // Apply one operation and check latency, busy length, result and single done pulse.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                        input logic eb, input string nm);
      int cyc;
      int bcnt;
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, 32'(cyc), 32'(WIDTH));
      check({nm, " busy_cycles"}, 32'(bcnt), 32'(WIDTH));
      check({nm, " busy_in_done"}, 32'(busy), 32'd0);
      check({nm, " diff"}, 32'(diff), 32'(ed));
      check({nm, " bout"}, 32'(bout), 32'(eb));
      @(negedge clk);
      check({nm, " done_width"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [8:0] r;
      int         rise[$];
      int         dcnt;
      int         post_busy;
      logic       prev_busy;
      logic [7:0] ra, rb;

      tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      tbl[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
      tbl[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
      tbl[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
      tbl[6] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

      // Reset with start held high: everything stays cleared.
      rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11;
      @(negedge clk);
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset diff", 32'(diff), 32'd0);
      check("reset bout", 32'(bout), 32'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("post_reset idle", 32'(busy), 32'd0);

      // Directed table.
      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].bout, $sformatf("tbl%0d", i));
      end

      // Result held in IDLE.
      repeat (4) @(negedge clk);
      check("idle hold diff", 32'(diff), 32'(tbl[7].diff));
      check("idle hold bout", 32'(bout), 32'(tbl[7].bout));

      // start pulsed at RUN cycle 3 and again in DONE: both ignored, one done pulse.
      @(negedge clk);
      a = 8'h40; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'hEE; b = 8'hDD;
      dcnt = 0; post_busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            dcnt++;
            check("ignore diff", 32'(diff), 32'h2F);
            check("ignore bout", 32'(bout), 32'd0);
            a = 8'hFF; b = 8'h00; start = 1'b1;
         end else begin
            start = 1'b0;
            if (dcnt > 0 && busy === 1'b1) post_busy++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore done_count", 32'(dcnt), 32'd1);
      check("ignore restart", 32'(post_busy), 32'd0);

      // Reset at RUN cycle 4 aborts immediately; start ignored while in reset.
      @(negedge clk);
      a = 8'h33; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort pre busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort diff", 32'(diff), 32'd0);
      check("abort bout", 32'(bout), 32'd0);
      start = 1'b1; a = 8'h44; b = 8'h22;
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dcnt++;
      end
      check("abort in_reset activity", 32'(dcnt), 32'd0);
      rst = 1'b0; start = 1'b0;
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      check("abort no_done", 32'(dcnt), 32'd0);
      do_op(8'h10, 8'h01, 8'h0F, 1'b0, "after_abort");

      // start held high: accept-to-accept interval is WIDTH+2.
      @(negedge clk);
      a = 8'h09; b = 8'h04; start = 1'b1;
      prev_busy = busy;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy === 1'b1 && prev_busy !== 1'b1) rise.push_back(i);
         prev_busy = busy;
      end
      start = 1'b0;
      if (rise.size() >= 2) check("interval", 32'(rise[1] - rise[0]), 32'(WIDTH + 2));
      else                  check("interval starts", 32'(rise.size()), 32'd2);
      repeat (12) @(negedge clk);
      check("interval diff", 32'(diff), 32'h05);

      // Sweep: every a against boundary b values, then random pairs.
      for (int ia = 0; ia < 256; ia++) begin
         logic [7:0] bset[8];
         ra = 8'(ia);
         bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h7F; bset[3] = 8'h80;
         bset[4] = 8'hFE; bset[5] = 8'hFF; bset[6] = ra;    bset[7] = ~ra;
         foreach (bset[j]) begin
            r = ref_sub(ra, bset[j]);
            do_op(ra, bset[j], r[7:0], r[8], "sweep");
         end
      end
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         r  = ref_sub(ra, rb);
         do_op(ra, rb, r[7:0], r[8], "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
